// File: rtl/arduino_link_rx_12bit.sv
// Receive end of the SCL/SS/MOSI serial sample link.
// Oversamples the link, deframes MSB-first words, buffers them in a FWFT FIFO.
module arduino_link_rx_12bit #(
   parameter int DATA_W      = 12,
   parameter int FIFO_DEPTH  = 4,
   parameter int SYNC_STAGES = 2,
   parameter int TIMEOUT     = 2000
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          SCL,
   input  logic                          SS,
   input  logic                          MOSI,
   output logic [DATA_W-1:0]             sample_data,
   output logic                          sample_valid,
   input  logic                          sample_ready,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
   output logic                          busy,
   output logic                          frame_err,
   output logic                          overflow
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int LW = AW + 1;
   localparam int BW = $clog2(DATA_W) + 1;
   localparam int TW = $clog2(TIMEOUT) + 1;

   typedef enum logic [1:0] {
      IDLE,
      SHIFT,
      WAIT_END
   } state_t;

   logic [SYNC_STAGES-1:0] scl_q, ss_q, mosi_q;
   logic                   scl_d, ss_d;
   logic                   scl_s, ss_s, mosi_s;
   logic                   scl_rise, ss_rise, ss_fall;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         scl_q  <= '1;
         ss_q   <= '1;
         mosi_q <= '0;
         scl_d  <= 1'b1;
         ss_d   <= 1'b1;
      end else begin
         scl_q  <= {scl_q[SYNC_STAGES-2:0], SCL};
         ss_q   <= {ss_q[SYNC_STAGES-2:0], SS};
         mosi_q <= {mosi_q[SYNC_STAGES-2:0], MOSI};
         scl_d  <= scl_s;
         ss_d   <= ss_s;
      end
   end

   assign scl_s    = scl_q[SYNC_STAGES-1];
   assign ss_s     = ss_q[SYNC_STAGES-1];
   assign mosi_s   = mosi_q[SYNC_STAGES-1];
   assign scl_rise = scl_s & ~scl_d;
   assign ss_rise  = ss_s & ~ss_d;
   assign ss_fall  = ~ss_s & ss_d;

   state_t            state, state_n;
   logic [BW-1:0]     bit_cnt, bit_cnt_n;
   logic [TW-1:0]     timer, timer_n;
   logic [DATA_W-1:0] shreg, shreg_n;
   logic              werr, werr_n;
   logic              err_n, push;
   logic [DATA_W-1:0] push_word;

   assign push_word = {shreg[DATA_W-2:0], mosi_s};

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state   <= IDLE;
         bit_cnt <= '0;
         timer   <= '0;
         shreg   <= '0;
         werr    <= 1'b0;
      end else begin
         state   <= state_n;
         bit_cnt <= bit_cnt_n;
         timer   <= timer_n;
         shreg   <= shreg_n;
         werr    <= werr_n;
      end
   end

   // SS rise has priority over a coincident SCL rise
   always_comb begin
      state_n   = state;
      bit_cnt_n = bit_cnt;
      timer_n   = timer;
      shreg_n   = shreg;
      werr_n    = werr;
      err_n     = 1'b0;
      push      = 1'b0;
      unique case (state)
         IDLE: begin
            if (ss_fall) begin
               state_n   = SHIFT;
               bit_cnt_n = '0;
               timer_n   = '0;
            end
         end
         SHIFT: begin
            if (ss_rise) begin
               err_n   = 1'b1;
               state_n = IDLE;
            end else if (scl_rise) begin
               shreg_n   = push_word;
               bit_cnt_n = bit_cnt + BW'(1);
               timer_n   = '0;
               if (bit_cnt == BW'(DATA_W - 1)) begin
                  push    = 1'b1;
                  werr_n  = 1'b0;
                  state_n = WAIT_END;
               end
            end else if (timer >= TW'(TIMEOUT - 1)) begin
               err_n   = 1'b1;
               werr_n  = 1'b1;
               state_n = WAIT_END;
            end else begin
               timer_n = timer + TW'(1);
            end
         end
         WAIT_END: begin
            if (ss_rise) begin
               state_n = IDLE;
            end else if (scl_rise && !werr) begin
               err_n  = 1'b1;
               werr_n = 1'b1;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   assign busy = (state != IDLE);

   logic [DATA_W-1:0] mem [FIFO_DEPTH];
   logic [AW:0]       wr_cnt, rd_cnt;
   logic              full, pop, wr_en;

   assign fifo_level   = wr_cnt - rd_cnt;
   assign sample_valid = (fifo_level != '0);
   assign full         = (fifo_level == LW'(FIFO_DEPTH));
   assign pop          = sample_valid & sample_ready;
   assign wr_en        = push & (~full | pop);
   assign sample_data  = sample_valid ? mem[rd_cnt[AW-1:0]] : '0;

   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_cnt[AW-1:0]] <= push_word;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_cnt    <= '0;
         rd_cnt    <= '0;
         frame_err <= 1'b0;
         overflow  <= 1'b0;
      end else begin
         if (wr_en) wr_cnt <= wr_cnt + LW'(1);
         if (pop)   rd_cnt <= rd_cnt + LW'(1);
         frame_err <= err_n;
         overflow  <= push & full & ~pop;
      end
   end

endmodule

// File: tb/tb_arduino_link_rx_12bit.sv
// Bench for arduino_link_rx_12bit: bit-banged link driver,
// queue-based word model and pulse counters.
module tb_arduino_link_rx_12bit;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        SCL = 1'b1;
   logic        SS = 1'b1;
   logic        MOSI = 1'b0;
   logic        sample_ready = 1'b0;
   logic [11:0] sample_data;
   logic        sample_valid;
   logic [2:0]  fifo_level;
   logic        busy;
   logic        frame_err;
   logic        overflow;

   int tests = 0;
   int fails = 0;
   int errs, ovfs, vcyc, maxlvl;
   logic [11:0] got[$];

   arduino_link_rx_12bit dut (
      .clk(clk), .rst(rst), .SCL(SCL), .SS(SS), .MOSI(MOSI),
      .sample_data(sample_data), .sample_valid(sample_valid),
      .sample_ready(sample_ready), .fifo_level(fifo_level),
      .busy(busy), .frame_err(frame_err), .overflow(overflow)
   );

   always #10 clk = ~clk;

   // observe away from the active edge
   always @(negedge clk) begin
      if (rst) begin
         if (sample_valid) vcyc++;
         if (sample_valid && sample_ready) got.push_back(sample_data);
         if (frame_err) errs++;
         if (overflow) ovfs++;
         if (int'(fifo_level) > maxlvl) maxlvl = int'(fifo_level);
      end
   end

   task automatic wclk(input int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   task automatic clear_mon();
      got.delete();
      errs = 0;
      ovfs = 0;
      vcyc = 0;
      maxlvl = 0;
   endtask

   task automatic drive_frame(input logic [11:0] w, input int nbits,
                              input int half, input bit end_ss);
      SS = 1'b0;
      wclk(half);
      for (int i = 0; i < nbits; i++) begin
         SCL = 1'b0;
         if (i < 12) MOSI = w[11-i];
         else MOSI = 1'($urandom);
         wclk(half);
         SCL = 1'b1;
         wclk(half);
      end
      if (end_ss) begin
         SS = 1'b1;
         wclk(2 * half);
      end
   endtask

   task automatic test_reset();
      rst = 1'b0;
      wclk(3);
      tests++;
      if ({sample_valid, busy, frame_err, overflow} !== 4'b0 ||
          fifo_level !== 3'd0 || sample_data !== 12'd0) begin
         fails++;
         $display("FAIL reset_hold: v=%b b=%b e=%b o=%b lvl=%0d d=%h, want all 0",
                  sample_valid, busy, frame_err, overflow, fifo_level, sample_data);
      end
      rst = 1'b1;
      wclk(5);
      tests++;
      if ({sample_valid, busy, frame_err, overflow} !== 4'b0 ||
          fifo_level !== 3'd0) begin
         fails++;
         $display("FAIL reset_release: v=%b b=%b e=%b o=%b lvl=%0d, want all 0",
                  sample_valid, busy, frame_err, overflow, fifo_level);
      end
   endtask

   task automatic test_single_100k();
      clear_mon();
      sample_ready = 1'b1;
      drive_frame(12'hA5C, 12, 250, 1'b1);
      wclk(5);
      tests++;
      if (got.size() !== 1 || got[0] !== 12'hA5C) begin
         fails++;
         $display("FAIL single_data: got %0d words first=%h, want 1 word a5c",
                  got.size(), (got.size() > 0) ? got[0] : 12'h0);
      end
      tests++;
      if (vcyc !== 1 || maxlvl !== 1 || fifo_level !== 3'd0) begin
         fails++;
         $display("FAIL single_level: vcyc=%0d max=%0d lvl=%0d, want 1 1 0",
                  vcyc, maxlvl, fifo_level);
      end
      tests++;
      if (errs !== 0 || ovfs !== 0) begin
         fails++;
         $display("FAIL single_flags: err=%0d ovf=%0d, want 0 0", errs, ovfs);
      end
   endtask

   task automatic test_overflow();
      clear_mon();
      sample_ready = 1'b0;
      for (int k = 1; k <= 5; k++) drive_frame(12'(k), 12, 10, 1'b1);
      wclk(4);
      tests++;
      if (fifo_level !== 3'd4 || ovfs !== 1 || sample_data !== 12'h001) begin
         fails++;
         $display("FAIL ovf_fill: lvl=%0d ovf=%0d head=%h, want 4 1 001",
                  fifo_level, ovfs, sample_data);
      end
      sample_ready = 1'b1;
      wclk(10);
      tests++;
      if (got.size() !== 4 || got[0] !== 12'h1 || got[1] !== 12'h2 ||
          got[2] !== 12'h3 || got[3] !== 12'h4 || fifo_level !== 3'd0) begin
         fails++;
         $display("FAIL ovf_drain: n=%0d lvl=%0d, want 001..004 lvl 0",
                  got.size(), fifo_level);
      end
   endtask

   task automatic test_short_frame();
      clear_mon();
      sample_ready = 1'b1;
      drive_frame(12'($urandom), 7, 10, 1'b1);
      wclk(4);
      tests++;
      if (errs !== 1 || got.size() !== 0 || fifo_level !== 3'd0 || busy !== 1'b0) begin
         fails++;
         $display("FAIL short_frame: err=%0d n=%0d lvl=%0d busy=%b, want 1 0 0 0",
                  errs, got.size(), fifo_level, busy);
      end
   endtask

   task automatic test_long_frame();
      logic [11:0] w;
      clear_mon();
      sample_ready = 1'b1;
      drive_frame(12'hC3F, 14, 10, 1'b1);
      wclk(4);
      tests++;
      if (errs !== 1 || got.size() !== 1 || got[0] !== 12'hC3F) begin
         fails++;
         $display("FAIL long_frame: err=%0d n=%0d first=%h, want 1 1 c3f",
                  errs, got.size(), (got.size() > 0) ? got[0] : 12'h0);
      end
      w = 12'($urandom);
      drive_frame(w, 12, 10, 1'b1);
      wclk(4);
      tests++;
      if (errs !== 1 || got.size() !== 2 || got[1] !== w) begin
         fails++;
         $display("FAIL long_next: err=%0d n=%0d, want err 1 and word %h", errs, got.size(), w);
      end
   endtask

   task automatic test_mid_reset();
      clear_mon();
      sample_ready = 1'b1;
      drive_frame(12'hFFF, 6, 10, 1'b0);
      rst = 1'b0;
      wclk(1);
      tests++;
      if ({sample_valid, busy, frame_err, overflow} !== 4'b0 || fifo_level !== 3'd0) begin
         fails++;
         $display("FAIL midrst_hold: v=%b b=%b e=%b o=%b lvl=%0d, want all 0",
                  sample_valid, busy, frame_err, overflow, fifo_level);
      end
      SS = 1'b1;
      SCL = 1'b1;
      wclk(4);
      rst = 1'b1;
      wclk(4);
      drive_frame(12'h3FF, 12, 10, 1'b1);
      wclk(4);
      tests++;
      if (got.size() !== 1 || got[0] !== 12'h3FF || errs !== 0) begin
         fails++;
         $display("FAIL midrst_after: n=%0d first=%h err=%0d, want 1 3ff 0",
                  got.size(), (got.size() > 0) ? got[0] : 12'h0, errs);
      end
   endtask

   task automatic test_timeout();
      clear_mon();
      sample_ready = 1'b1;
      SS = 1'b0;
      wclk(10);
      for (int i = 0; i < 3; i++) begin
         SCL = 1'b0;
         MOSI = 1'($urandom);
         wclk(10);
         SCL = 1'b1;
         wclk(10);
      end
      wclk(1880);
      tests++;
      if (errs !== 0 || busy !== 1'b1) begin
         fails++;
         $display("FAIL timeout_early: err=%0d busy=%b, want 0 1", errs, busy);
      end
      wclk(300);
      tests++;
      if (errs !== 1 || fifo_level !== 3'd0 || busy !== 1'b1) begin
         fails++;
         $display("FAIL timeout_fire: err=%0d lvl=%0d busy=%b, want 1 0 1",
                  errs, fifo_level, busy);
      end
      SS = 1'b1;
      wclk(10);
      tests++;
      if (busy !== 1'b0 || got.size() !== 0 || errs !== 1) begin
         fails++;
         $display("FAIL timeout_end: busy=%b n=%0d err=%0d, want 0 0 1",
                  busy, got.size(), errs);
      end
   endtask

   task automatic test_random_fill();
      logic [11:0] sent[$];
      int k, keep;
      for (int r = 0; r < 6; r++) begin
         clear_mon();
         sent.delete();
         sample_ready = 1'b0;
         k = $urandom_range(1, 6);
         for (int j = 0; j < k; j++) begin
            sent.push_back(12'($urandom));
            drive_frame(sent[j], 12, $urandom_range(6, 15), 1'b1);
         end
         wclk(4);
         keep = (k < 4) ? k : 4;
         tests++;
         if (int'(fifo_level) !== keep || ovfs !== k - keep) begin
            fails++;
            $display("FAIL rand_fill r%0d: lvl=%0d ovf=%0d, want %0d %0d",
                     r, fifo_level, ovfs, keep, k - keep);
         end
         sample_ready = 1'b1;
         wclk(8);
         sample_ready = 1'b0;
         tests++;
         if (got.size() !== keep || got != sent[0:keep-1]) begin
            fails++;
            $display("FAIL rand_drain r%0d: n=%0d, want %0d words in order",
                     r, got.size(), keep);
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [11:0] sent[$];
      clear_mon();
      sample_ready = 1'b1;
      for (int j = 0; j < 10; j++) begin
         sent.push_back(12'($urandom));
         drive_frame(sent[j], 12, $urandom_range(4, 12), 1'b1);
      end
      wclk(6);
      tests++;
      if (got != sent || errs !== 0 || ovfs !== 0) begin
         fails++;
         $display("FAIL back_to_back: n=%0d err=%0d ovf=%0d, want 10 words 0 0",
                  got.size(), errs, ovfs);
      end
   endtask

   initial begin
      clear_mon();
      test_reset();
      test_single_100k();
      test_overflow();
      test_short_frame();
      test_long_frame();
      test_mid_reset();
      test_timeout();
      test_random_fill();
      test_back_to_back();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
